// File: rtl/rvc_align_pkg.sv
// Shared types and helpers for the RV32IC parcel aligner.
// A parcel is one 16-bit halfword of the instruction stream.
package rvc_align_pkg;

  localparam int PARCEL_W = 16;
  localparam int PTR_W    = 4;

  typedef logic [PARCEL_W-1:0] parcel_t;

  // A parcel whose low two bits are not 2'b11 starts a 16-bit instruction.
  function automatic logic is_rvc(parcel_t p);
    return p[1:0] != 2'b11;
  endfunction

  // Advance a ring pointer by n (0..2) entries for a ring of any depth.
  // ptr < depth and n < depth, so one conditional subtract is enough.
  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] ptr,
                                                logic [1:0]       n,
                                                logic [PTR_W-1:0] depth);
    logic [PTR_W-1:0] sum;
    sum = ptr + {2'b00, n};
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

endpackage

// File: rtl/rvc_parcel_buf.sv
// Circular parcel store: pushes 0..2 parcels and pops 0..2 parcels per cycle,
// exposing the occupancy and the two oldest parcels.
module rvc_parcel_buf
  import rvc_align_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic [1:0]    push_n,
  input  parcel_t       push_lo,
  input  parcel_t       push_hi,
  input  logic [1:0]    pop_n,
  output logic [CW-1:0] count,
  output parcel_t       peek0,
  output parcel_t       peek1
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_W = PTR_W'(DEPTH);

  parcel_t          mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PTR_W-1:0] head_plus1;
  logic [PTR_W-1:0] head_step;
  logic [PTR_W-1:0] tail_plus1;
  logic [PTR_W-1:0] tail_step;
  logic [CW-1:0]    count_next;

  // Wrapped pointer arithmetic and the two head-side read ports.
  always_comb begin
    head_plus1 = ptr_inc(PTR_W'(head), 2'd1, DEPTH_W);
    head_step  = ptr_inc(PTR_W'(head), pop_n, DEPTH_W);
    tail_plus1 = ptr_inc(PTR_W'(tail), 2'd1, DEPTH_W);
    tail_step  = ptr_inc(PTR_W'(tail), push_n, DEPTH_W);
    count_next = count + CW'(push_n) - CW'(pop_n);
    peek0      = mem[head];
    peek1      = mem[head_plus1[PW-1:0]];
  end

  // Pointer and occupancy state; reset and clear both empty the ring.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_step[PW-1:0];
      tail  <= tail_step[PW-1:0];
      count <= count_next;
    end
  end

  // Parcel storage; the lower parcel always lands at the tail slot.
  always_ff @(posedge clock) begin
    if (!reset && !clear) begin
      if (push_n != 2'd0) mem[tail] <= push_lo;
      if (push_n == 2'd2) mem[tail_plus1[PW-1:0]] <= push_hi;
    end
  end

endmodule

// File: rtl/rvc_parcel_aligner.sv
// Splits a stream of 32-bit fetch words into whole RV32IC instructions,
// one per output handshake, with support for halfword-aligned redirects.
module rvc_parcel_aligner
  import rvc_align_pkg::*;
#(
  parameter int BUF_PARCELS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        flush_hi,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic        out_compressed
);

  localparam int CW = $clog2(BUF_PARCELS + 1);
  localparam logic [CW-1:0] FILL_LIMIT = CW'(BUF_PARCELS - 2);
  localparam logic [CW-1:0] TWO        = CW'(2);

  logic [CW-1:0] count;
  parcel_t       h0;
  parcel_t       h1;
  parcel_t       push_lo;
  parcel_t       push_hi;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic          skip_lo;
  logic          head_rvc;
  logic          insn_avail;
  logic          accept;
  logic          consume;

  rvc_parcel_buf #(
    .DEPTH (BUF_PARCELS),
    .CW    (CW)
  ) u_buf (
    .clock   (clock),
    .reset   (reset),
    .clear   (flush),
    .push_n  (push_n),
    .push_lo (push_lo),
    .push_hi (push_hi),
    .pop_n   (pop_n),
    .count   (count),
    .peek0   (h0),
    .peek1   (h1)
  );

  // Decode the head, drive the handshakes and pick how many parcels move.
  always_comb begin
    head_rvc       = is_rvc(h0);
    insn_avail     = ((count != '0) && head_rvc) || ((count >= TWO) && !head_rvc);
    out_valid      = insn_avail && !flush;
    in_ready       = (count <= FILL_LIMIT) && !flush;
    out_compressed = out_valid && head_rvc;
    out_insn       = '0;
    if (out_valid) out_insn = head_rvc ? {16'h0000, h0} : {h1, h0};
    accept         = in_valid && in_ready;
    consume        = out_valid && out_ready;
    push_lo        = skip_lo ? in_data[31:16] : in_data[15:0];
    push_hi        = in_data[31:16];
    push_n         = accept ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
    pop_n          = consume ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
  end

  // Remember that the next accepted word starts at its upper parcel.
  always_ff @(posedge clock) begin
    if (reset)       skip_lo <= 1'b0;
    else if (flush)  skip_lo <= flush_hi;
    else if (accept) skip_lo <= 1'b0;
  end

endmodule

// File: tb/tb_rvc_parcel_aligner.sv
// Self-checking bench for rvc_parcel_aligner: directed cases plus a random
// stream compared against a parcel-queue reference model.
module tb_rvc_parcel_aligner;

  localparam int BUF_PARCELS = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        flush_hi;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        out_compressed;

  int errors = 0;
  int checks = 0;

  logic [15:0] model_q[$];
  logic        model_skip = 1'b0;

  logic [31:0] last_insn;
  logic        last_valid;
  logic        last_comp;
  logic        last_ready;

  rvc_parcel_aligner #(.BUF_PARCELS(BUF_PARCELS)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .flush_hi       (flush_hi),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_insn       (out_insn),
    .out_compressed (out_compressed)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] rand_parcel();
    logic [15:0] p;
    p = 16'($urandom);
    if (p[1:0] == 2'b11 && p[4:2] == 3'b111) p[4] = 1'b0;
    return p;
  endfunction

  // Drive one cycle, compare against the queue model, then advance the model.
  task automatic applyStimulus(input logic rst, input logic fl, input logic fl_hi,
                               input logic iv, input logic [31:0] data,
                               input logic ordy);
    logic        exp_valid;
    logic        exp_comp;
    logic        exp_ready;
    logic [31:0] exp_insn;
    logic [15:0] p0;
    int          n;
    reset     = rst;
    flush     = fl;
    flush_hi  = fl_hi;
    in_valid  = iv;
    in_data   = data;
    out_ready = ordy;
    #3;
    last_insn  = out_insn;
    last_valid = out_valid;
    last_comp  = out_compressed;
    last_ready = in_ready;
    n         = model_q.size();
    exp_valid = 1'b0;
    exp_comp  = 1'b0;
    exp_insn  = 32'h0;
    if (n >= 1) begin
      p0 = model_q[0];
      if (p0[1:0] != 2'b11) begin
        exp_valid = 1'b1;
        exp_comp  = 1'b1;
        exp_insn  = {16'h0000, p0};
      end else if (n >= 2) begin
        exp_valid = 1'b1;
        exp_insn  = {model_q[1], p0};
      end
    end
    exp_ready = (n <= BUF_PARCELS - 2);
    if (fl) begin
      exp_valid = 1'b0;
      exp_comp  = 1'b0;
      exp_insn  = 32'h0;
      exp_ready = 1'b0;
    end
    if (!rst) begin
      checkOutput("out_valid", {31'b0, last_valid}, {31'b0, exp_valid});
      checkOutput("out_insn", last_insn, exp_insn);
      checkOutput("out_compressed", {31'b0, last_comp}, {31'b0, exp_comp});
      checkOutput("in_ready", {31'b0, last_ready}, {31'b0, exp_ready});
    end
    if (rst) begin
      model_q.delete();
      model_skip = 1'b0;
    end else if (fl) begin
      model_q.delete();
      model_skip = fl_hi;
    end else begin
      if (exp_valid && ordy) begin
        void'(model_q.pop_front());
        if (!exp_comp) void'(model_q.pop_front());
      end
      if (iv && exp_ready) begin
        if (!model_skip) model_q.push_back(data[15:0]);
        model_q.push_back(data[31:16]);
        model_skip = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; flush_hi = 1'b0;
    in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    @(posedge clock);
    #1;

    applyStimulus(1, 0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    checkOutput("reset_valid", {31'b0, last_valid}, 32'h0);
    checkOutput("reset_insn", last_insn, 32'h0);
    checkOutput("reset_ready", {31'b0, last_ready}, 32'h1);

    applyStimulus(0, 0, 0, 1, 32'h00A00513, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("addi_insn", last_insn, 32'h00A00513);
    checkOutput("addi_comp", {31'b0, last_comp}, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("addi_drained", {31'b0, last_valid}, 32'h0);

    applyStimulus(0, 0, 0, 1, 32'h45814501, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("cli_first", last_insn, 32'h00004501);
    checkOutput("cli_first_comp", {31'b0, last_comp}, 32'h1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("cli_second", last_insn, 32'h00004581);
    checkOutput("cli_second_comp", {31'b0, last_comp}, 32'h1);

    applyStimulus(0, 0, 0, 1, 32'h05134501, 1);
    applyStimulus(0, 0, 0, 1, 32'h000100A0, 1);
    checkOutput("straddle_c", last_insn, 32'h00004501);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("straddle_32", last_insn, 32'h00A00513);
    checkOutput("straddle_32_comp", {31'b0, last_comp}, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("straddle_nop", last_insn, 32'h00000001);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);

    applyStimulus(0, 1, 1, 0, 32'h0, 1);
    checkOutput("flush_valid", {31'b0, last_valid}, 32'h0);
    checkOutput("flush_ready", {31'b0, last_ready}, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h4501DEAD, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("flush_hi_insn", last_insn, 32'h00004501);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("flush_hi_no_dead", {31'b0, last_valid}, 32'h0);

    applyStimulus(0, 0, 0, 1, 32'h00A00513, 0);
    applyStimulus(0, 0, 0, 1, 32'h00B00593, 0);
    checkOutput("bp_hold_1", last_insn, 32'h00A00513);
    applyStimulus(0, 0, 0, 1, 32'h00C00613, 0);
    checkOutput("bp_in_ready_low", {31'b0, last_ready}, 32'h0);
    checkOutput("bp_hold_2", last_insn, 32'h00A00513);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("bp_drain_1", last_insn, 32'h00A00513);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("bp_drain_2", last_insn, 32'h00B00593);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);

    applyStimulus(0, 0, 0, 1, 32'h05134501, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("half_held_valid", {31'b0, last_valid}, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("mid_reset_valid", {31'b0, last_valid}, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h45814501, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("fresh_align", last_insn, 32'h00004501);

    for (int i = 0; i < 800; i++) begin
      logic r_rst;
      logic r_fl;
      logic r_hi;
      logic r_iv;
      logic r_rdy;
      r_rst = ($urandom_range(0, 79) == 0);
      r_fl  = ($urandom_range(0, 29) == 0);
      r_hi  = 1'($urandom_range(0, 1));
      r_iv  = ($urandom_range(0, 9) < 7);
      r_rdy = ($urandom_range(0, 9) < 6);
      applyStimulus(r_rst, r_fl, r_hi, r_iv, {rand_parcel(), rand_parcel()}, r_rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
